// File: rtl/nbiot_dmrs_seq_gen.sv
// NB-IoT uplink DMRS generator: single-tone Gold/Hadamard or multi-tone phase-table sequences,
// mapped through an 8-point phase wheel and streamed with valid/ready backpressure.
module nbiot_dmrs_seq_gen #(
  parameter int W     = 16,
  parameter int LEN_W = 12,
  parameter int NC    = 1600
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [30:0]         cinit,
  input  logic [3:0]          had_row,
  input  logic [3:0]          nsc,
  input  logic [1:0]          cs,
  input  logic [LEN_W-1:0]    seq_len,
  input  logic                tbl_we,
  input  logic [3:0]          tbl_addr,
  input  logic [1:0]          tbl_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [LEN_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam longint F_L = longint'(1) <<< (W - 2);
  localparam longint A_L = (F_L * 64'sd70710678 + 64'sd50000000) / 64'sd100000000;
  localparam logic signed [W-1:0] F_P = W'(F_L);
  localparam logic signed [W-1:0] A_P = W'(A_L);
  localparam logic signed [W-1:0] F_N = -F_P;
  localparam logic signed [W-1:0] A_N = -A_P;
  localparam int CW = $clog2(NC + 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(NC - 1);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic             mode_r;
  logic [3:0]       had_r;
  logic [3:0]       nsc_r;
  logic [1:0]       cs_r;
  logic [LEN_W-1:0] len_r;
  logic [30:0]      x1;
  logic [30:0]      x2;
  logic [CW-1:0]    wcnt;
  logic [LEN_W-1:0] gen_n;
  logic [3:0]       mod_cnt;
  logic [1:0]       tbl [12];

  logic             c_bit;
  logic             had_par;
  logic [1:0]       q;
  logic [1:0]       csn;
  logic [2:0]       st_phase;
  logic [2:0]       mt_phase;
  logic [2:0]       phase;
  logic signed [W-1:0] nre;
  logic signed [W-1:0] nim;
  logic             load;
  logic             xfer;
  logic [3:0]       nsc_eff;

  function automatic logic [30:0] x1_step(input logic [30:0] s);
    return {s[3] ^ s[0], s[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] s);
    return {s[3] ^ s[2] ^ s[1] ^ s[0], s[30:1]};
  endfunction

  // Next-sample phase for the generator index gen_n; LFSR bit 0 holds c(gen_n).
  always_comb begin
    c_bit    = x1[0] ^ x2[0];
    had_par  = ^(had_r & gen_n[3:0]);
    q        = tbl[mod_cnt];
    csn      = 2'(gen_n[1:0] * cs_r);
    st_phase = {c_bit ^ had_par, 2'b01};
    mt_phase = {q, 1'b1} + {csn, 1'b0};
    phase    = mode_r ? mt_phase : st_phase;
  end

  always_comb begin
    nre = '0;
    nim = '0;
    case (phase)
      3'd0:    begin nre = F_P;  nim = '0;   end
      3'd1:    begin nre = A_P;  nim = A_P;  end
      3'd2:    begin nre = '0;   nim = F_P;  end
      3'd3:    begin nre = A_N;  nim = A_P;  end
      3'd4:    begin nre = F_N;  nim = '0;   end
      3'd5:    begin nre = A_N;  nim = A_N;  end
      3'd6:    begin nre = '0;   nim = F_N;  end
      default: begin nre = A_P;  nim = A_N;  end
    endcase
  end

  always_comb begin
    nsc_eff = 4'd12;
    if (nsc == 4'd3 || nsc == 4'd6) nsc_eff = nsc;
  end

  // The output register refills whenever it is empty or being drained this cycle.
  assign load = (state == RUN) && (gen_n != len_r) && (!out_valid || out_ready);
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 12; i++) tbl[i] <= '0;
    end else if (tbl_we && !busy && tbl_addr < 4'd12) begin
      tbl[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      had_r     <= '0;
      nsc_r     <= '0;
      cs_r      <= '0;
      len_r     <= '0;
      x1        <= '0;
      x2        <= '0;
      wcnt      <= '0;
      gen_n     <= '0;
      mod_cnt   <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (start) begin
            mode_r  <= mode;
            had_r   <= had_row;
            nsc_r   <= nsc_eff;
            cs_r    <= cs;
            len_r   <= seq_len;
            x1      <= 31'd1;
            x2      <= cinit;
            wcnt    <= '0;
            gen_n   <= '0;
            mod_cnt <= '0;
            if (seq_len == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= mode ? RUN : WARMUP;
            end
          end
        end
        WARMUP: begin
          x1   <= x1_step(x1);
          x2   <= x2_step(x2);
          wcnt <= wcnt + CW'(1);
          if (wcnt == WARM_LAST) state <= RUN;
        end
        RUN: begin
          if (load) begin
            out_valid <= 1'b1;
            out_re    <= nre;
            out_im    <= nim;
            out_idx   <= gen_n;
            out_last  <= (gen_n == len_r - LEN_W'(1));
            gen_n     <= gen_n + LEN_W'(1);
            mod_cnt   <= (mod_cnt == nsc_r - 4'd1) ? 4'd0 : mod_cnt + 4'd1;
            x1        <= x1_step(x1);
            x2        <= x2_step(x2);
          end else if (xfer) begin
            out_valid <= 1'b0;
          end
          if (xfer && out_last) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbiot_dmrs_seq_gen.sv
// Randomized directed bench for nbiot_dmrs_seq_gen against a sequence-level reference model.
module tb_nbiot_dmrs_seq_gen;

  localparam int  W     = 16;
  localparam int  LEN_W = 12;
  localparam int  NC    = 1600;
  localparam real PI    = 3.14159265358979;
  localparam real FS    = 16384.0;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [30:0]      cinit;
  logic [3:0]       had_row;
  logic [3:0]       nsc;
  logic [1:0]       cs;
  logic [LEN_W-1:0] seq_len;
  logic             tbl_we;
  logic [3:0]       tbl_addr;
  logic [1:0]       tbl_data;
  logic             out_valid;
  logic             out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic [LEN_W-1:0] out_idx;
  logic             out_last;
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_re[$];
  int exp_im[$];
  bit [1:0] mtbl [12];

  nbiot_dmrs_seq_gen #(.W(W), .LEN_W(LEN_W), .NC(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cinit(cinit),
    .had_row(had_row), .nsc(nsc), .cs(cs), .seq_len(seq_len),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Reference: phase k -> F*exp(j*k*pi/4); Gold sequence from the 3GPP recurrences.
  function automatic void build_exp(input bit m, input bit [30:0] ci, input bit [3:0] u,
                                    input bit [3:0] ns, input bit [1:0] c, input int len);
    int tot;
    int nsc_e;
    int p;
    bit x1[];
    bit x2[];
    exp_re.delete();
    exp_im.delete();
    tot = NC + len + 31;
    x1 = new[tot];
    x2 = new[tot];
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = ci[i];
    end
    for (int i = 31; i < tot; i++) begin
      x1[i] = x1[i-28] ^ x1[i-31];
      x2[i] = x2[i-28] ^ x2[i-29] ^ x2[i-30] ^ x2[i-31];
    end
    nsc_e = (ns == 3 || ns == 6) ? int'(ns) : 12;
    for (int n = 0; n < len; n++) begin
      if (!m)
        p = 1 + 4 * ((x1[n+NC] ^ x2[n+NC]) ^ ($countones(u & 4'(n % 16)) % 2));
      else
        p = (2 * mtbl[n % nsc_e] + 1 + 2 * c * n) % 8;
      exp_re.push_back(rnd(FS * $cos(p * PI / 4.0)));
      exp_im.push_back(rnd(FS * $sin(p * PI / 4.0)));
    end
  endfunction

  task automatic tbl_write(input bit [3:0] a, input bit [1:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    tick();
    tbl_we = 1'b0;
    if (a < 12) mtbl[a] = d;
  endtask

  task automatic run_req(input string tag, input bit m, input bit [30:0] ci, input bit [3:0] u,
                         input bit [3:0] ns, input bit [1:0] c, input int len,
                         input int duty, input bit spam);
    int  cyc, n, budget, exp_lat;
    bit  first, held, got_done, last_hs;
    logic signed [W-1:0] h_re, h_im;
    logic [LEN_W-1:0] h_idx;
    logic h_last;
    build_exp(m, ci, u, ns, c, len);
    exp_lat = m ? 2 : NC + 2;
    budget  = exp_lat + 40 * len + 50;
    mode = m; cinit = ci; had_row = u; nsc = ns; cs = c; seq_len = LEN_W'(len);
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = ~m; cinit = ~ci; had_row = ~u; nsc = 4'd1; cs = ~c; seq_len = '1;
    cyc = 1;
    if (len == 0) begin
      chk({tag, "_done_t1"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_novalid"}, out_valid, 0);
      tick();
      chk({tag, "_done_once"}, done, 0);
      chk({tag, "_novalid2"}, out_valid, 0);
      return;
    end
    chk({tag, "_busy_t1"}, busy, 1);
    first = 1; held = 0; got_done = 0; n = 0;
    while (!got_done && cyc < budget) begin
      out_ready = ($urandom_range(99) < duty);
      if (spam) begin
        tbl_we = 1'b1; tbl_addr = 4'($urandom_range(11)); tbl_data = 2'($urandom);
      end
      if (held) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_re"}, out_re, h_re);
        chk({tag, "_hold_im"}, out_im, h_im);
        chk({tag, "_hold_idx"}, out_idx, h_idx);
        chk({tag, "_hold_last"}, out_last, h_last);
      end
      held = 0;
      last_hs = 0;
      if (out_valid) begin
        if (first) begin
          chk({tag, "_latency"}, cyc, exp_lat);
          first = 0;
        end
        if (out_ready) begin
          chk({tag, "_inrange"}, n < len, 1);
          if (n < len) begin
            chk({tag, "_idx"}, out_idx, n);
            chk({tag, "_re"}, out_re, exp_re[n]);
            chk({tag, "_im"}, out_im, exp_im[n]);
            chk({tag, "_last"}, out_last, n == len - 1);
          end
          n++;
          last_hs = (n == len);
        end else begin
          held = 1; h_re = out_re; h_im = out_im; h_idx = out_idx; h_last = out_last;
        end
      end
      tick();
      cyc++;
      if (done) begin
        got_done = 1;
        chk({tag, "_count"}, n, len);
        chk({tag, "_done_after_last"}, last_hs, 1);
        chk({tag, "_valid_off"}, out_valid, 0);
        chk({tag, "_busy_off"}, busy, 0);
      end
    end
    tbl_we = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_done_seen"}, got_done, 1);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bit [30:0] rc;
    rst = 1'b1; start = 0; mode = 0; cinit = '0; had_row = '0; nsc = 4'd12; cs = '0;
    seq_len = '0; tbl_we = 0; tbl_addr = '0; tbl_data = '0; out_ready = 0;
    for (int i = 0; i < 12; i++) mtbl[i] = 2'd0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    rst = 1'b0;
    tick();

    run_req("t1_q0", 1, 0, 0, 12, 0, 24, 100, 0);
    run_req("t2_cs1", 1, 0, 0, 12, 1, 16, 100, 0);

    for (int a = 0; a < 16; a++) tbl_write(4'(a), 2'($urandom));
    run_req("mt_nsc3", 1, 0, 0, 3, 2, 20, 100, 0);
    run_req("mt_nsc6", 1, 0, 0, 6, 3, 20, 100, 0);
    run_req("mt_nsc_bad", 1, 0, 0, 5, 2'($urandom), 30, 100, 0);

    run_req("t3_u0", 0, 31'd35, 4'd0, 12, 0, 32, 100, 0);
    run_req("t3_u5", 0, 31'd35, 4'd5, 12, 0, 32, 100, 0);

    run_req("bp_mt", 1, 0, 0, 12, 2'($urandom), 40, 30, 0);
    rc = 31'($urandom);
    run_req("bp_st", 0, rc, 4'($urandom), 3, 0, 25, 30, 0);

    for (int a = 0; a < 12; a++) tbl_write(4'(a), 2'd3);
    mode = 0; cinit = 31'd35; had_row = 0; seq_len = 32; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 800; i++) tick();
    chk("t5_busy_warm", busy, 1);
    chk("t5_novalid_warm", out_valid, 0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) mtbl[i] = 2'd0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_valid", out_valid, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_re", out_re, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_done", done, 0);
    end
    run_req("t5_rerun", 0, 31'd35, 4'd0, 12, 0, 32, 100, 0);
    run_req("t5_tbl_clr", 1, 0, 0, 12, 0, 12, 100, 0);

    run_req("t6_len0_st", 0, 31'd35, 4'd5, 12, 0, 0, 100, 0);
    run_req("t6_len0_mt", 1, 0, 0, 12, 0, 0, 100, 0);
    for (int a = 0; a < 12; a++) tbl_write(4'(a), 2'($urandom));
    run_req("t6_spam", 1, 0, 0, 12, 1, 24, 60, 1);
    run_req("t6_oldtbl", 1, 0, 0, 12, 0, 24, 100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
